uart_line_loader: RTL and testbench
===================================

# uart_line_loader

Parametrised ASCII-hex line loader between `uart_rx` and the line-buffer BRAM write port. It parses a byte stream of hex digits and control characters, packs digits into a line-wide accumulator, and emits one write per committed line. It generalises the old top-level loader with:
- parametrised line width and depth
- explicit line addressing
- lowercase hex support
- error counting

## Interface
- `LINE_BITS`, 300, pixel bits per line; `NIBBLES = ceil(LINE_BITS/4)`
- `NUM_LINES`, 608, lines in the buffer; valid addresses 0..NUM_LINES-1
- `ADDR_W`, 10, line address width; `ADDR_DIGITS = ceil(ADDR_W/4)`
- `i_CLK`  in  1  single clock, 27 MHz domain of `uart_rx`
- `i_RST`  in  1  reset, asynchronous, active-high
- `i_RX_READY`  in  1  `uart_rx` o_READY level; a byte is taken on each rising edge
- `i_RX_DATA`  in  8  `uart_rx` o_DATA, stable while `i_RX_READY` is high
- `o_WR_EN`  out  1  one-cycle BRAM write strobe
- `o_WR_ADDR`  out  ADDR_W  line address of the write
- `o_WR_DATA`  out  LINE_BITS  line contents of the write
- `o_LINE_IDX`  out  ADDR_W  current target line
- `o_ERR_CNT`  out  8  saturating count of protocol errors

## Operation
- **Byte take:** a byte is taken when `i_RX_READY` is high and was low in the previous cycle. Holding `i_RX_READY` high is one byte.
- **State S_DATA (reset state):**
  - `#`: line=0, nibble index=0, accumulator cleared. No write.
  - `+`: commit.
    - `o_WR_ADDR`=line, `o_WR_DATA`=accumulator, `o_WR_EN` pulses.
    - Then line=line+1, wrapping NUM_LINES-1→0. Nibble index=0, accumulator cleared.
  - `0-9 A-F a-f`: nibble k = nibble index goes to accumulator bits [4k+3:4k]; the first digit is the LSBs. Bits at or above LINE_BITS are dropped; index increments.
    - If the index is already NIBBLES, the digit is discarded and counts as an error.
  - `@`: go to S_ADDR, address shift register cleared, digit count=0.
  - CR, LF, space: ignored, no error.
  - Any other byte: error; state unchanged.
- **State S_ADDR:**
  - Hex digit: address = (address<<4)|digit, MSB-first. Count increments.
  - After ADDR_DIGITS digits:
    - Value < NUM_LINES: line=value; nibble index and accumulator cleared.
    - Otherwise: error, line unchanged.
    - Either way, return to S_DATA.
  - Non-hex byte: error, line unchanged, return to S_DATA, byte otherwise discarded.
- **Partial line:** a commit with fewer than NIBBLES digits writes zeros in unfilled nibbles.
- **Error counter:** `o_ERR_CNT` saturates at 255. It is cleared only by reset; `#` does not clear it.
- **Reset:** all outputs 0, state S_DATA, accumulator 0, edge-detect register 0. Reset mid-line discards the partial line and never produces a write.

## Timing
- Edge registered in cycle N (`i_RX_READY`=1, previous=0). The byte is processed at the clock edge ending cycle N, so `o_WR_EN`=1 in cycle N+1 only.
- `o_WR_ADDR`/`o_WR_DATA` are registered. They are valid with `o_WR_EN` and hold until the next commit.
- `o_LINE_IDX` and `o_ERR_CNT` update in cycle N+1.
- Throughput: one byte per 2 cycles minimum. `uart_rx` at 2.2 Mbaud gives ≥100 cycles per byte.
- `i_RX_DATA` is sampled in the edge cycle only.

## Structure
- Package `uart_loader_pkg`: char constants (`#`, `+`, `@`, CR, LF, space), state enum {S_DATA, S_ADDR}, function `hex2nib(byte) -> {valid, nibble[3:0]}` covering both cases.
- No sub-module. The edge detect, FSM, accumulator and counter stay in one module.

## Test plan
- **Single line:** reset, send `#12+` → one `o_WR_EN` pulse, addr 0, data 0x21, `o_LINE_IDX`=1, `o_ERR_CNT`=0.
- **Wrap-around:** `#` then 609× `+` → writes to addresses 0..607 then 0, each data 0.
- **Line addressing:** `@1F4A+` → write addr 500, data 0xA, `o_LINE_IDX`=501. Then `@3FF` → `o_ERR_CNT`=1, `o_LINE_IDX` stays 501.
- **Overlong line:** 76× `f` then `+` → data all ones (300 bits), `o_ERR_CNT`+1.
- **Ready level:** `+` with `i_RX_READY` held high 10 cycles → exactly one write. `G` → `o_ERR_CNT`+1. LF → no change.
- **Reset mid-line:** `#AB` then assert `i_RST` asynchronously between clock edges → all outputs 0 immediately. After release, `+` writes addr 0, data 0.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared constants, FSM state type and hex decode helper for the UART line loader.
package uart_loader_pkg;

  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_AT   = 8'h40;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_SP   = 8'h20;

  typedef enum logic {
    S_DATA,
    S_ADDR
  } state_e;

  // Returns {valid, nibble}; accepts 0-9, A-F and a-f.
  function automatic logic [4:0] hex2nib(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
    return r;
  endfunction

endpackage

// File: rtl/uart_line_loader.sv
// ASCII-hex line loader: turns a uart_rx byte stream into line-wide BRAM writes.
module uart_line_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned LINE_BITS = 300,
  parameter int unsigned NUM_LINES = 608,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic                 i_RX_READY,
  input  logic [7:0]           i_RX_DATA,
  output logic                 o_WR_EN,
  output logic [ADDR_W-1:0]    o_WR_ADDR,
  output logic [LINE_BITS-1:0] o_WR_DATA,
  output logic [ADDR_W-1:0]    o_LINE_IDX,
  output logic [7:0]           o_ERR_CNT
);

  localparam int unsigned NIBBLES     = (LINE_BITS + 3) / 4;
  localparam int unsigned ADDR_DIGITS = (ADDR_W + 3) / 4;
  localparam int unsigned IDX_W       = $clog2(NIBBLES + 1);
  localparam int unsigned CNT_W       = $clog2(ADDR_DIGITS + 1);
  localparam int unsigned SHIFT_W     = 4 * ADDR_DIGITS;
  localparam int unsigned PB_W        = $clog2(LINE_BITS);

  state_e               state_q, state_d;
  logic                 rdy_prev_q, rdy_prev_d;
  logic [IDX_W-1:0]     nib_idx_q, nib_idx_d;
  logic [LINE_BITS-1:0] acc_q, acc_d;
  logic [SHIFT_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]    line_q, line_d;
  logic [7:0]           err_q, err_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [LINE_BITS-1:0] wr_data_q, wr_data_d;

  logic                 take;
  logic [4:0]           hex;
  logic [3:0]           nib;
  logic                 err_inc;
  logic [IDX_W+1:0]     base;
  logic [SHIFT_W-1:0]   shifted;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q    <= S_DATA;
      rdy_prev_q <= 1'b0;
      nib_idx_q  <= '0;
      acc_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      line_q     <= '0;
      err_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rdy_prev_q <= rdy_prev_d;
      nib_idx_q  <= nib_idx_d;
      acc_q      <= acc_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      err_q      <= err_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rdy_prev_d = i_RX_READY;
    nib_idx_d  = nib_idx_q;
    acc_d      = acc_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_inc    = 1'b0;

    take    = i_RX_READY && !rdy_prev_q;
    hex     = hex2nib(i_RX_DATA);
    nib     = hex[3:0];
    base    = {nib_idx_q, 2'b00};
    shifted = (addr_q << 4) | SHIFT_W'(nib);

    if (take) begin
      unique case (state_q)
        S_DATA: begin
          if (hex[4]) begin
            if (nib_idx_q == IDX_W'(NIBBLES)) begin
              err_inc = 1'b1;
            end else begin
              // Bits of the last nibble that fall past LINE_BITS are dropped.
              for (int unsigned b = 0; b < 4; b++) begin
                if (32'(base) + b < LINE_BITS)
                  acc_d[PB_W'(32'(base) + b)] = nib[b[1:0]];
              end
              nib_idx_d = nib_idx_q + 1'b1;
            end
          end else begin
            case (i_RX_DATA)
              CH_HASH: begin
                line_d    = '0;
                nib_idx_d = '0;
                acc_d     = '0;
              end
              CH_PLUS: begin
                wr_en_d   = 1'b1;
                wr_addr_d = line_q;
                wr_data_d = acc_q;
                line_d    = (line_q == ADDR_W'(NUM_LINES - 1)) ? '0 : line_q + 1'b1;
                nib_idx_d = '0;
                acc_d     = '0;
              end
              CH_AT: begin
                state_d = S_ADDR;
                addr_d  = '0;
                cnt_d   = '0;
              end
              CH_CR, CH_LF, CH_SP: ;
              default: err_inc = 1'b1;
            endcase
          end
        end
        S_ADDR: begin
          if (hex[4]) begin
            addr_d = shifted;
            if (cnt_q == CNT_W'(ADDR_DIGITS - 1)) begin
              state_d = S_DATA;
              if (32'(shifted) < NUM_LINES) begin
                line_d    = ADDR_W'(shifted);
                nib_idx_d = '0;
                acc_d     = '0;
              end else begin
                err_inc = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            err_inc = 1'b1;
            state_d = S_DATA;
          end
        end
        default: state_d = S_DATA;
      endcase
    end

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  assign o_WR_EN    = wr_en_q;
  assign o_WR_ADDR  = wr_addr_q;
  assign o_WR_DATA  = wr_data_q;
  assign o_LINE_IDX = line_q;
  assign o_ERR_CNT  = err_q;

endmodule

// File: tb/tb_uart_line_loader.sv
// Randomised scoreboard bench for uart_line_loader against a queue-based line model.
module tb_uart_line_loader;

  localparam int unsigned LINE_BITS   = 300;
  localparam int unsigned NUM_LINES   = 608;
  localparam int unsigned ADDR_W      = 10;
  localparam int unsigned NIBBLES     = 75;
  localparam int unsigned ADDR_DIGITS = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 rx_ready = 1'b0;
  logic [7:0]           rx_data = 8'h00;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [LINE_BITS-1:0] wr_data;
  logic [ADDR_W-1:0]    line_idx;
  logic [7:0]           err_cnt;

  uart_line_loader #(
    .LINE_BITS(LINE_BITS),
    .NUM_LINES(NUM_LINES),
    .ADDR_W   (ADDR_W)
  ) dut (
    .i_CLK     (clk),
    .i_RST     (rst),
    .i_RX_READY(rx_ready),
    .i_RX_DATA (rx_data),
    .o_WR_EN   (wr_en),
    .o_WR_ADDR (wr_addr),
    .o_WR_DATA (wr_data),
    .o_LINE_IDX(line_idx),
    .o_ERR_CNT (err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int                   addr;
    logic [LINE_BITS-1:0] data;
  } wr_t;
  wr_t exp_q[$];
  int  writes_seen = 0;
  int  writes_exp  = 0;

  // Behavioural model of the loader.
  int m_line, m_err, m_in_addr, m_addr_val, m_addr_cnt;
  int m_nibs[$];

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  task automatic check(input string name, input logic [LINE_BITS-1:0] act,
                       input logic [LINE_BITS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_line = 0; m_err = 0; m_in_addr = 0; m_addr_val = 0; m_addr_cnt = 0;
    m_nibs.delete();
  endtask

  task automatic model_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_byte(input logic [7:0] c);
    int  v;
    wr_t w;
    v = hexval(c);
    if (m_in_addr != 0) begin
      m_in_addr = 0;
      if (v < 0) model_err();
      else begin
        m_addr_val = m_addr_val * 16 + v;
        m_addr_cnt++;
        if (m_addr_cnt < ADDR_DIGITS) m_in_addr = 1;
        else if (m_addr_val < NUM_LINES) begin
          m_line = m_addr_val;
          m_nibs.delete();
        end else model_err();
      end
    end else if (v >= 0) begin
      if (m_nibs.size() < NIBBLES) m_nibs.push_back(v);
      else model_err();
    end else if (c == "#") begin
      m_line = 0;
      m_nibs.delete();
    end else if (c == "+") begin
      w.addr = m_line;
      w.data = '0;
      foreach (m_nibs[k]) w.data = w.data | (LINE_BITS'(m_nibs[k]) << (4 * k));
      exp_q.push_back(w);
      writes_exp++;
      m_line = (m_line + 1) % NUM_LINES;
      m_nibs.delete();
    end else if (c == "@") begin
      m_in_addr = 1; m_addr_val = 0; m_addr_cnt = 0;
    end else if (c == 8'h0D || c == 8'h0A || c == 8'h20) begin
    end else model_err();
  endtask

  // Drive one byte with READY held for `hold` cycles, then compare the visible state.
  task automatic send_byte(input logic [7:0] c, input int hold);
    @(negedge clk);
    rx_data  = c;
    rx_ready = 1'b1;
    model_byte(c);
    repeat (hold) @(negedge clk);
    rx_ready = 1'b0;
    rx_data  = 8'($urandom);
    repeat ($urandom_range(1, 3)) @(negedge clk);
    check("line_idx", LINE_BITS'(line_idx), LINE_BITS'(m_line));
    check("err_cnt", LINE_BITS'(err_cnt), LINE_BITS'(m_err));
  endtask

  task automatic send_str(input string s);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      send_byte(c, $urandom_range(1, 3));
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t w;
    if (!rst && wr_en) begin
      writes_seen++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", wr_addr, wr_data);
      end else begin
        w = exp_q.pop_front();
        if (int'(wr_addr) != w.addr || wr_data !== w.data) begin
          n_fail++;
          $display("FAIL write: got addr %0d data %0h expected addr %0d data %0h",
                   wr_addr, wr_data, w.addr, w.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    int         r;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_wr_en", LINE_BITS'(wr_en), '0);
    check("reset_wr_addr", LINE_BITS'(wr_addr), '0);
    check("reset_wr_data", wr_data, '0);
    check("reset_line_idx", LINE_BITS'(line_idx), '0);
    check("reset_err_cnt", LINE_BITS'(err_cnt), '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single line: first digit lands in the LSBs.
    send_str("#12+");
    check("single_line_idx", LINE_BITS'(line_idx), LINE_BITS'(1));
    check("single_wr_data", wr_data, LINE_BITS'(12'h021));

    // Wrap-around over the full buffer.
    send_str("#");
    for (int i = 0; i < NUM_LINES + 1; i++) send_byte("+", 1);
    check("wrap_line_idx", LINE_BITS'(line_idx), LINE_BITS'(1));

    // Explicit addressing and out-of-range address.
    send_str("@1F4A+");
    check("addr_wr_addr", LINE_BITS'(wr_addr), LINE_BITS'(500));
    check("addr_line_idx", LINE_BITS'(line_idx), LINE_BITS'(501));
    send_str("@3FF");
    check("bad_addr_line_idx", LINE_BITS'(line_idx), LINE_BITS'(501));

    // Overlong line: 76 digits, the last one rejected.
    for (int i = 0; i < NIBBLES + 1; i++) send_byte("f", 1);
    send_byte("+", 1);
    check("overlong_data", wr_data, '1);

    // READY held high counts once; bad byte and LF.
    send_byte("+", 10);
    send_str("G");
    send_byte(8'h0A, 2);
    send_str("@1x0a+");
    send_str("\r 3c+");

    // Reset mid-line discards the partial line, asynchronously.
    send_str("#AB");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    exp_q.delete();
    check("arst_wr_en", LINE_BITS'(wr_en), '0);
    check("arst_wr_addr", LINE_BITS'(wr_addr), '0);
    check("arst_wr_data", wr_data, '0);
    check("arst_line_idx", LINE_BITS'(line_idx), '0);
    check("arst_err_cnt", LINE_BITS'(err_cnt), '0);
    @(negedge clk);
    rst = 1'b0;
    send_str("+");
    check("post_rst_data", wr_data, '0);

    // Randomised byte stream.
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45) begin
        c = 8'($urandom_range(0, 15));
        case ($urandom_range(0, 1))
          0: c = (c < 10) ? 8'("0") + c : 8'("A") + c - 8'd10;
          default: c = (c < 10) ? 8'("0") + c : 8'("a") + c - 8'd10;
        endcase
      end else if (r < 60) c = "+";
      else if (r < 65) c = "#";
      else if (r < 72) c = "@";
      else if (r < 80) c = 8'h20;
      else c = 8'($urandom_range(0, 255));
      send_byte(c, $urandom_range(1, 4));
    end

    // Error counter saturation.
    while (m_err < 258 && err_cnt != 8'hFF) send_byte("G", 1);
    repeat (3) send_byte("z", 1);
    check("err_saturate", LINE_BITS'(err_cnt), LINE_BITS'(255));

    repeat (4) @(negedge clk);
    check("pending_writes", LINE_BITS'(exp_q.size()), '0);
    check("write_count", LINE_BITS'(writes_seen), LINE_BITS'(writes_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
